// File: rtl/instr_trace_buffer.sv
// instr_trace_buffer: retire-trace capture stage behind a single-cycle core.
// Samples pc/instr every clock, pushes each distinct PC as one entry into a
// first-word-fall-through FIFO, drains over a valid/ready port, detects a
// self-loop halt and counts entries dropped on overflow.
//
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   pc, instr         - core fetch pair sampled every rising edge
//   trace_en          - capture enable
//   out_valid/ready   - drain handshake; out_pc/out_instr show the head entry
//   count             - entries stored (0..DEPTH)
//   drop_count        - entries lost to a full FIFO, saturating
//   overflow          - sticky, set on first drop
//   halted            - sticky, PC unchanged for HALT_CYCLES captures-enabled edges
module instr_trace_buffer #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned HALT_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              pc,
  input  logic [31:0]              instr,
  input  logic                     trace_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              drop_count,
  output logic                     overflow,
  output logic                     halted
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned SAME_W = $clog2(HALT_CYCLES + 1);

  logic [63:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [15:0]       drop_count_q, drop_count_d;
  logic              overflow_q, overflow_d;
  logic              halted_q, halted_d;
  logic              first_q, first_d;
  logic [31:0]       last_pc_q, last_pc_d;
  logic [SAME_W-1:0] same_cnt_q, same_cnt_d;

  logic pop, push_req, full, do_push, drop;

  // Capture decision, FIFO bookkeeping and halt detection.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    drop_count_d = drop_count_q;
    overflow_d   = overflow_q;
    first_d      = first_q;
    last_pc_d    = last_pc_q;
    same_cnt_d   = same_cnt_q;

    pop      = (count_q != '0) && out_ready;
    push_req = trace_en && !halted_q && (first_q || (pc != last_pc_q));
    full     = (count_q == CNT_W'(DEPTH));
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    do_push  = push_req && (!full || pop);
    drop     = push_req && full && !pop;

    // last_pc tracks captures even when the entry is dropped, so the
    // de-dup and halt logic follow the core rather than FIFO occupancy.
    if (trace_en && !halted_q) begin
      if (push_req) begin
        first_d    = 1'b0;
        last_pc_d  = pc;
        same_cnt_d = '0;
      end else if (same_cnt_q != SAME_W'(HALT_CYCLES)) begin
        same_cnt_d = same_cnt_q + SAME_W'(1);
      end
    end
    halted_d = halted_q || (same_cnt_d == SAME_W'(HALT_CYCLES));

    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({do_push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
    end
  end

  // Control state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
      halted_q     <= 1'b0;
      first_q      <= 1'b1;
      last_pc_q    <= '0;
      same_cnt_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
      halted_q     <= halted_d;
      first_q      <= first_d;
      last_pc_q    <= last_pc_d;
      same_cnt_q   <= same_cnt_d;
    end
  end

  // Entry storage; contents are only observable while valid, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {pc, instr};
  end

  // Head entry falls through from storage; forced to zero while empty so
  // the reset-state outputs are all zero.
  assign out_valid  = (count_q != '0);
  assign out_pc     = out_valid ? mem_q[rd_ptr_q][63:32] : 32'd0;
  assign out_instr  = out_valid ? mem_q[rd_ptr_q][31:0]  : 32'd0;
  assign count      = count_q;
  assign drop_count = drop_count_q;
  assign overflow   = overflow_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_instr_trace_buffer.sv
// Self-checking bench for instr_trace_buffer: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_instr_trace_buffer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned HALT  = 4;

  logic        clk;
  logic        reset;
  logic [31:0] pc, instr;
  logic        trace_en;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr;
  logic [4:0]  count;
  logic [15:0] drop_count;
  logic        overflow, halted;

  instr_trace_buffer #(.DEPTH(DEPTH), .HALT_CYCLES(HALT)) dut (
    .clk(clk), .reset(reset), .pc(pc), .instr(instr), .trace_en(trace_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .count(count), .drop_count(drop_count),
    .overflow(overflow), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: trace entries as a queue, plus capture/halt status.
  logic [63:0] mq[$];
  bit          m_first;
  logic [31:0] m_last;
  int          m_stable;
  bit          m_halted;
  int          m_drops;
  bit          m_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_first  = 1'b1;
    m_last   = '0;
    m_stable = 0;
    m_halted = 1'b0;
    m_drops  = 0;
    m_ovf    = 1'b0;
  endtask

  // Apply one clock edge's worth of the rules to the model.
  task automatic model_edge();
    bit popped;
    bit want;
    popped = (mq.size() != 0) && out_ready;
    want   = trace_en && !m_halted && (m_first || pc != m_last);
    if (popped) void'(mq.pop_front());
    if (trace_en && !m_halted) begin
      if (want) begin
        m_first  = 1'b0;
        m_last   = pc;
        m_stable = 0;
        if (mq.size() < DEPTH) mq.push_back({pc, instr});
        else begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
      end else begin
        m_stable++;
        if (m_stable >= HALT) m_halted = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, 64'(count),      64'(mq.size()));
    check({tag, ".valid"}, 64'(out_valid),  64'(mq.size() != 0));
    check({tag, ".drops"}, 64'(drop_count), 64'(m_drops));
    check({tag, ".ovf"},   64'(overflow),   64'(m_ovf));
    check({tag, ".halt"},  64'(halted),     64'(m_halted));
    if (mq.size() != 0) check({tag, ".head"}, {out_pc, out_instr}, mq[0]);
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #2;
    check_all("arst");
    check("arst.pc",    64'(out_pc),    64'd0);
    check("arst.instr", 64'(out_instr), 64'd0);
    #2;
    reset = 1'b0;
  endtask

  logic [31:0] sl_pc [4];
  logic [31:0] sl_in [4];

  initial begin
    sl_pc = '{32'h00, 32'h04, 32'h08, 32'h0C};
    sl_in = '{32'h00500093, 32'h00300113, 32'h002081B3, 32'h00000013};

    // Reset values
    reset = 1'b1; pc = '0; instr = '0; trace_en = 1'b0; out_ready = 1'b0;
    model_reset();
    #2;
    check_all("rst");
    #8;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step("idle");
      check("idle.pc",    64'(out_pc),    64'd0);
      check("idle.instr", 64'(out_instr), 64'd0);
    end

    // Straight-line program, then drain
    trace_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc = sl_pc[i]; instr = sl_in[i];
      step("sl_fill");
    end
    check("sl.count4", 64'(count), 64'd4);
    trace_en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("sl.drain_pc",    64'(out_pc),    64'(sl_pc[i]));
      check("sl.drain_instr", 64'(out_instr), 64'(sl_in[i]));
      step("sl_drain");
    end
    check("sl.empty", 64'(out_valid), 64'd0);

    // Halt detection
    do_reset();
    out_ready = 1'b0; trace_en = 1'b1;
    pc = 32'h00; instr = 32'h13; step("h0");
    pc = 32'h04; step("h1");
    pc = 32'h08; instr = 32'h0000006F; step("hK");
    for (int i = 1; i < HALT; i++) begin
      step("h_wait");
      check("h.not_yet", 64'(halted), 64'd0);
    end
    step("h_rise");
    check("h.halted", 64'(halted), 64'd1);
    check("h.count3", 64'(count),  64'd3);
    pc = 32'h0C; step("h_after");
    check("h.no_push", 64'(count), 64'd3);

    // Overflow with 20 distinct PCs
    do_reset();
    out_ready = 1'b0; trace_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pc = 32'(i * 4); instr = 32'(32'hA000 + i);
      step("ov_fill");
    end
    check("ov.count", 64'(count),      64'd16);
    check("ov.drops", 64'(drop_count), 64'd4);
    check("ov.flag",  64'(overflow),   64'd1);
    trace_en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("ov.drain_pc", 64'(out_pc), 64'(i * 4));
      step("ov_drain");
    end
    check("ov.empty", 64'(out_valid), 64'd0);

    // Full with simultaneous push and pop across pointer wrap
    do_reset();
    out_ready = 1'b0; trace_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pc = 32'(i * 4); instr = 32'(i);
      step("fp_fill");
    end
    out_ready = 1'b1;
    for (int i = 16; i < 40; i++) begin
      check("fp.head_pc", 64'(out_pc), 64'((i - 16) * 4));
      pc = 32'(i * 4); instr = 32'(i);
      step("fp_stream");
      check("fp.count", 64'(count),      64'd16);
      check("fp.drops", 64'(drop_count), 64'd0);
    end

    // Reset mid-operation with count=7, halted=1, overflow=1
    do_reset();
    out_ready = 1'b0; trace_en = 1'b1;
    for (int i = 0; i < 18; i++) begin
      pc = 32'(32'h100 + i * 4); instr = 32'(i);
      step("mr_fill");
    end
    for (int i = 0; i < HALT; i++) step("mr_hold");
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) step("mr_drain");
    out_ready = 1'b0;
    check("mr.count7", 64'(count),    64'd7);
    check("mr.halted", 64'(halted),   64'd1);
    check("mr.ovf",    64'(overflow), 64'd1);
    #2;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pc = 32'(32'h200 + i * 4); instr = 32'(32'h55 + i);
      step("mr_resume");
    end
    check("mr.resume_cnt", 64'(count),  64'd3);
    check("mr.resume_pc",  64'(out_pc), 64'h200);

    // Randomized traffic with occasional asynchronous resets
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 60) pc = 32'($urandom_range(0, 7) * 4);
      instr     = $urandom;
      trace_en  = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 3) == 0);
      step("rnd");
      if ($urandom_range(0, 149) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
